// File: rtl/vec_alu_pkg.sv
// Shared encodings for the vector ALU engine: opcodes, FSM states and host memory selects.
package vec_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLL  = 3'd5;
  localparam logic [2:0] OP_SRL  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_OP  = 2'd2;
  localparam logic [1:0] SEL_RES = 2'd3;

endpackage

// File: rtl/vec_alu_engine_sp_ram.sv
// Single-port synchronous RAM, one-cycle read latency, read-before-write.
module sp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vec_alu_engine.sv
// Vector ALU engine: host-loaded A/B/OP memories, element-wise or reduction pass into RESULT.
// state   | meaning
// S_IDLE  | host access, waiting for start
// S_RUN   | issuing one element address per cycle
// S_DRAIN | last element in the ALU stage
// S_DONE  | first cycle writes back acc (wb), then done_o until start_i drops
module vec_alu_engine
  import vec_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            host_sel_i,
  input  logic                  host_we_i,
  input  logic                  host_en_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] acc_o
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  function automatic logic [DATA_WIDTH-1:0] vec_alu_op(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b,
                                                      input logic [2:0]            op);
    logic [DATA_WIDTH-1:0] r;
    logic [SHW-1:0]        sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      default: r = a;
    endcase
    return r;
  endfunction

  state_t                state, state_nx;
  logic                  mode, s1_valid, wb, rd_pend;
  logic [ADDR_WIDTH-1:0] base, issue_addr, s1_addr, opnd_addr, res_addr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] acc, alu_res, res_wdata, rd_hold;
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [1:0]            rd_sel;
  logic                  run, host_ok, host_wr, host_rd, res_we;

  assign run     = (state == S_RUN);
  assign host_ok = (state == S_IDLE) || ((state == S_DONE) && !wb);
  assign host_wr = host_ok && host_en_i && host_we_i;
  assign host_rd = host_ok && host_en_i && !host_we_i;
  assign busy_o  = run || (state == S_DRAIN);
  assign done_o  = (state == S_DONE) && !wb;
  assign acc_o   = acc;
  assign alu_res = vec_alu_op(a_q, b_q, op_q[2:0]);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_i) state_nx = (len_i == '0) ? S_DONE : S_RUN;
      S_RUN:   if (cnt == CNT_ONE) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_DONE;
      default: if (!wb && !start_i) state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode       <= 1'b0;
      base       <= '0;
      issue_addr <= '0;
      cnt        <= '0;
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      wb         <= 1'b0;
      acc        <= '0;
    end else begin
      s1_valid <= run;
      s1_addr  <= issue_addr;
      wb       <= (state == S_DRAIN);
      if ((state == S_IDLE) && start_i) begin
        mode       <= mode_i;
        base       <= base_i;
        issue_addr <= base_i;
        cnt        <= len_i;
        acc        <= '0;
      end
      if (run) begin
        issue_addr <= issue_addr + ADDR_ONE;
        cnt        <= cnt - CNT_ONE;
      end
      if (s1_valid && mode) acc <= acc + alu_res;
    end
  end

  assign opnd_addr = run ? issue_addr : host_addr_i;

  // RESULT port is shared by stage-1 writes, the reduction write-back and the host.
  always_comb begin
    res_addr  = host_addr_i;
    res_we    = host_wr && (host_sel_i == SEL_RES);
    res_wdata = host_wdata_i;
    if (s1_valid && !mode) begin
      res_addr  = s1_addr;
      res_we    = 1'b1;
      res_wdata = alu_res;
    end else if (wb && mode) begin
      res_addr  = base;
      res_we    = 1'b1;
      res_wdata = acc;
    end
    if (RST) res_we = 1'b0;
  end

  sp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram_a (
    .clk(CLK), .we(host_wr && (host_sel_i == SEL_A)), .addr(opnd_addr),
    .wdata(host_wdata_i), .rdata(a_q));

  sp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram_b (
    .clk(CLK), .we(host_wr && (host_sel_i == SEL_B)), .addr(opnd_addr),
    .wdata(host_wdata_i), .rdata(b_q));

  sp_ram #(.DATA_WIDTH(OP_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram_op (
    .clk(CLK), .we(host_wr && (host_sel_i == SEL_OP)), .addr(opnd_addr),
    .wdata(host_wdata_i[OP_WIDTH-1:0]), .rdata(op_q));

  sp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram_res (
    .clk(CLK), .we(res_we), .addr(res_addr), .wdata(res_wdata), .rdata(res_q));

  // Read data comes straight off the RAM the cycle after an honoured read, else holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend <= 1'b0;
      rd_sel  <= SEL_A;
      rd_hold <= '0;
    end else begin
      rd_pend <= host_rd;
      rd_sel  <= host_sel_i;
      rd_hold <= host_rdata_o;
    end
  end

  always_comb begin
    host_rdata_o = rd_hold;
    if (rd_pend) begin
      case (rd_sel)
        SEL_A:   host_rdata_o = a_q;
        SEL_B:   host_rdata_o = b_q;
        SEL_OP:  host_rdata_o = DATA_WIDTH'(op_q);
        default: host_rdata_o = res_q;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_engine.sv
// Directed bench for vec_alu_engine: host reads are scoreboarded against a bench-side memory model.
module tb_vec_alu_engine;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [1:0]    host_sel = 2'd0;
  logic          host_we = 1'b0;
  logic          host_en = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [DW-1:0] host_rdata;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done;
  logic [DW-1:0] acc;

  vec_alu_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST),
    .host_sel_i(host_sel), .host_we_i(host_we), .host_en_i(host_en),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_rdata_o(host_rdata),
    .start_i(start), .mode_i(mode), .base_i(base), .len_i(len),
    .busy_o(busy), .done_o(done), .acc_o(acc));

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mdl [4][DEPTH];
  logic [31:0] sb [$];
  logic [31:0] last_rd = '0;
  logic [31:0] exp2 [8];

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << s;
      3'd6:    return a >> s;
      default: return a;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] s, input int addr, input logic [31:0] d);
    host_sel = s; host_addr = addr[AW-1:0]; host_wdata = d; host_we = 1'b1; host_en = 1'b1;
    tick();
    host_en = 1'b0; host_we = 1'b0;
    mdl[s][addr] = (s == 2'd2) ? {29'd0, d[2:0]} : d;
  endtask

  task automatic rd(input logic [1:0] s, input int addr, input logic [31:0] exp, input string tag);
    logic [31:0] want;
    host_sel = s; host_addr = addr[AW-1:0]; host_we = 1'b0; host_en = 1'b1;
    sb.push_back(exp);
    tick();
    host_en = 1'b0;
    want = sb.pop_front();
    chk(tag, host_rdata, want);
    last_rd = want;
  endtask

  task automatic run_pass(input logic m, input int b, input int l, input string tag, input bit poke);
    int n, bc, a, exp_n;
    logic [31:0] acc_exp;
    acc_exp = '0;
    for (int k = 0; k < l; k++) begin
      a = (b + k) % DEPTH;
      acc_exp += ref_alu(mdl[0][a], mdl[1][a], mdl[2][a][2:0]);
    end
    mode = m; base = b[AW-1:0]; len = l[AW:0]; start = 1'b1;
    tick();
    n = 1; bc = 0;
    while (done !== 1'b1 && n < l + 20) begin
      if (busy === 1'b1) bc++;
      if (poke && n == 3) begin
        host_sel = 2'd0; host_addr = 10'd2; host_wdata = 32'h5555; host_we = 1'b1; host_en = 1'b1;
      end
      if (poke && n == 5) begin
        host_sel = 2'd1; host_addr = 10'd7; host_we = 1'b0; host_en = 1'b1;
      end
      if (poke && (n == 4 || n == 6)) begin host_en = 1'b0; host_we = 1'b0; end
      if (poke && n == 6) chk({tag, "_rdata_hold_busy"}, host_rdata, last_rd);
      tick();
      n++;
    end
    exp_n = (l == 0) ? 1 : l + 3;
    chk({tag, "_done_latency"}, n, exp_n);
    chk({tag, "_busy_cycles"}, bc, (l == 0) ? 0 : l + 1);
    if (m) chk({tag, "_acc"}, acc, acc_exp);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk($sformatf("%s_held_start_%0d", tag, h), {30'd0, busy, done}, 32'd1);
    end
    start = 1'b0;
    tick();
    chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
    if (!m) begin
      for (int k = 0; k < l; k++) begin
        a = (b + k) % DEPTH;
        mdl[3][a] = ref_alu(mdl[0][a], mdl[1][a], mdl[2][a][2:0]);
      end
    end else if (l > 0) begin
      mdl[3][b % DEPTH] = acc_exp;
    end
  endtask

  initial begin
    exp2[0] = 32'hFFFFF1EF; exp2[1] = 32'hE1E1EFF1; exp2[2] = 32'h000000F0; exp2[3] = 32'hFFFFF0FF;
    exp2[4] = 32'hFFFFF00F; exp2[5] = 32'h00000000; exp2[6] = 32'h00000001; exp2[7] = 32'hF0F0F0F0;

    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_acc", acc, 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    RST = 1'b0;
    tick();

    // Element-wise ADD over 16 words, with a host write and read attempted while busy.
    for (int i = 0; i < 16; i++) begin
      wr(2'd0, i, i);
      wr(2'd1, i, 2 * i);
      wr(2'd2, i, 0);
    end
    rd(2'd0, 5, 32'd5, "pre_read_a5");
    run_pass(1'b0, 0, 16, "ew16", 1'b1);
    rd(2'd0, 2, 32'd2, "a2_busy_write_dropped");
    for (int i = 0; i < 16; i++) rd(2'd3, i, 3 * i, $sformatf("ew16_res_%0d", i));

    // Every opcode against one operand pair.
    for (int i = 0; i < 8; i++) begin
      wr(2'd0, i, 32'hF0F0F0F0);
      wr(2'd1, i, 32'h0F0F00FF);
      wr(2'd2, i, i);
    end
    run_pass(1'b0, 0, 8, "ops", 1'b0);
    for (int i = 0; i < 8; i++) rd(2'd3, i, exp2[i], $sformatf("op_%0d", i));

    // Address wrap past the top of memory.
    for (int j = 0; j < 8; j++) begin
      wr(2'd0, (1020 + j) % DEPTH, j * 7 + 3);
      wr(2'd1, (1020 + j) % DEPTH, j + 1);
      wr(2'd2, (1020 + j) % DEPTH, j);
    end
    wr(2'd3, 4, 32'hDEAD);
    run_pass(1'b0, 1020, 8, "wrap", 1'b0);
    for (int j = 0; j < 8; j++)
      rd(2'd3, (1020 + j) % DEPTH, mdl[3][(1020 + j) % DEPTH], $sformatf("wrap_res_%0d", (1020 + j) % DEPTH));
    rd(2'd3, 4, 32'hDEAD, "wrap_untouched_4");

    // Reduction: sum of 1..10 written back to RESULT[base] only.
    for (int i = 0; i < 10; i++) begin
      wr(2'd0, 5 + i, i + 1);
      wr(2'd1, 5 + i, 0);
      wr(2'd2, 5 + i, 0);
    end
    for (int i = 6; i <= 14; i++) wr(2'd3, i, 32'h1000 + i);
    run_pass(1'b1, 5, 10, "red", 1'b0);
    chk("red_acc_55", acc, 32'd55);
    rd(2'd3, 5, 32'd55, "red_res_5");
    for (int i = 6; i <= 14; i++) rd(2'd3, i, 32'h1000 + i, $sformatf("red_untouched_%0d", i));

    // Zero-length pass.
    wr(2'd3, 20, 32'hBEEF);
    run_pass(1'b0, 20, 0, "len0", 1'b0);
    rd(2'd3, 20, 32'hBEEF, "len0_no_write");

    // Reset mid-pass: elements 0..3 land before the reset edge.
    for (int i = 0; i < 16; i++) begin
      wr(2'd0, i, 100 + i);
      wr(2'd1, i, 0);
      wr(2'd2, i, 7);
    end
    mode = 1'b0; base = '0; len = 11'd16; start = 1'b1;
    tick();
    repeat (5) tick();
    RST = 1'b1; start = 1'b0;
    tick();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) mdl[3][i] = 100 + i;
    tick();
    for (int i = 0; i < 16; i++) rd(2'd3, i, mdl[3][i], $sformatf("midrst_res_%0d", i));
    run_pass(1'b0, 0, 16, "after_rst", 1'b0);
    for (int i = 0; i < 16; i++) rd(2'd3, i, 100 + i, $sformatf("after_rst_res_%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
